fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Frame scheduler between the FIR filter output and the 16-point FFT. Collects the serial FIR sample stream into 16-sample frames using a ping-pong buffer. Presents each complete frame to the FFT in parallel over a valid/ready handshake, and flags overflow. Counts frames and asserts `done` once the programmed number of frames has been handed over.

## Interface
- `FRAME_LEN`, default 16: samples per frame. Fixed at 16; the FFT is 16-point.
- `DW`, default 16: sample width, signed Q-format as produced by the FIR.
- `TOTAL_FRAMES`, default 64: frames to deliver before `done`. Legal range is 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fir_valid` in 1: `fir_d` carries a valid sample this cycle.
- `fir_d` in 16: FIR output sample.
- `frame_valid` out 1: a complete frame is presented on `frame_d`.
- `frame_ready` in 1: the FFT accepts the presented frame this cycle.
- `frame_d` out 256 (FRAME_LEN*DW): sample k occupies bits [16k+15:16k]; k=0 is the oldest sample.
- `frame_idx` out 8: index of the frame currently presented (0-based).
- `ovf` out 1: sticky; at least one sample was dropped.
- `done` out 1: high from completion until reset.

## Operation
- Storage: two banks B0/B1, each 16×16 bits. Each bank has a registered `full` flag.
- Write pointer `wr_bank` and write counter `wr_cnt` (0..15). Read pointer `rd_bank`.
- `sent_cnt` counts frames handed over; `fill_cnt` counts frames completed. Both are 8 bits.
- FSM states:
  - IDLE (reset state): enter RUN on the first `fir_valid`; that sample is accepted.
  - RUN: accept samples. When `fill_cnt` reaches `TOTAL_FRAMES`, go to DRAIN.
  - DRAIN: ignore `fir_valid`. When `sent_cnt` reaches `TOTAL_FRAMES`, go to DONE.
  - DONE: `done`=1. Ignore all inputs; `frame_valid`=0. Only `rst` exits this state.
- Sample accept (IDLE/RUN, `fir_valid`=1, `full[wr_bank]`=0):
  - Write `fir_d` to `bank[wr_bank][wr_cnt]` and increment `wr_cnt`.
  - At `wr_cnt`=15: set `full[wr_bank]`, toggle `wr_bank`, clear `wr_cnt`, increment `fill_cnt`.
- Drop: `fir_valid`=1 while `full[wr_bank]`=1 (registered value) in IDLE/RUN.
  - The sample is discarded and `ovf` is set.
  - No pointer moves, so the partial-frame position is kept.
  - A bank being drained in the same cycle is not usable until the next cycle.
- Read side: `frame_valid` = `full[rd_bank]` in RUN/DRAIN; `frame_d` = `bank[rd_bank]`.
- On `frame_valid`&`frame_ready`: clear `full[rd_bank]`, toggle `rd_bank`, increment `sent_cnt`.
- `frame_idx` = `sent_cnt`.
- Gaps in `fir_valid` are legal. A partial frame is held indefinitely and is never flushed or zero-padded.
- Simultaneous fill completion on one bank and handshake on the other bank is legal; both take effect.

## Timing
- Reset values:
  - `frame_valid`=0, `frame_d`=0 (banks cleared), `frame_idx`=0, `ovf`=0, `done`=0.
  - FSM=IDLE; all pointers and counters 0; both `full` flags 0.
- Latency: `frame_valid` rises in the cycle after the edge that captures the 16th sample.
- Handshake rules:
  - `frame_valid` is held until `frame_ready`.
  - `frame_d` and `frame_idx` are stable while `frame_valid`=1 and no handshake has occurred.
  - Back-to-back frames: if the other bank is full, `frame_valid` stays high in the cycle after a handshake with the new frame's data.
- `done` rises in the cycle after the handshake of frame `TOTAL_FRAMES`-1.
- `rst` asserted mid-frame or mid-handshake: everything returns to reset values immediately (asynchronous). Partial data is lost.

## Test plan
- Reset: assert `rst` with random inputs → all outputs 0 and FSM in IDLE; release reset → no `frame_valid` without samples.
- Single frame: `frame_ready`=1; feed 16 contiguous samples 0x0000..0x000F → `frame_valid` for 1 cycle, one cycle after the 16th edge. `frame_d` word k = k, `frame_idx`=0.
- Backpressure/overflow:
  - With `frame_ready`=0, feed 33 samples 0..32 → both banks full, sample 32 dropped, `ovf`=1.
  - Then raise `frame_ready` → frame 0 (words 0..15) is accepted, then frame 1 (words 16..31) in the next cycle. `frame_idx` goes 0 then 1.
- Gapped input: feed 16 samples with `fir_valid` toggling 1/0 → one frame with contents in order; no drop; `ovf`=0.
- Completion with `TOTAL_FRAMES`=2: deliver 48 samples with `frame_ready`=1 → 2 handshakes, `done`=1 in the cycle after the second handshake. Samples 32..47 are ignored, with no third `frame_valid` and `ovf`=0.
- Reset mid-operation: assert `rst` after 8 samples of frame 0 → all outputs reset. Then 16 new samples 100..115 → `frame_d` holds 100..115 with `frame_idx`=0.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_frame_ctrl                                                             |
// | Ping-pong framing of the FIR sample stream into 16-sample FFT frames.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module fft_frame_ctrl #(
    parameter int FRAME_LEN    = 16,
    parameter int DW           = 16,
    parameter int TOTAL_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fir_valid,
    input  logic [DW-1:0]           fir_d,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [FRAME_LEN*DW-1:0] frame_d,
    output logic [7:0]              frame_idx,
    output logic                    ovf,
    output logic                    done
);

    localparam int                 c_cnt_w     = $clog2(FRAME_LEN);
    localparam logic [c_cnt_w-1:0] c_last_word = c_cnt_w'(FRAME_LEN - 1);
    localparam logic [7:0]         c_total     = 8'(TOTAL_FRAMES);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]                        r_state;
    logic [1:0][FRAME_LEN-1:0][DW-1:0] r_bank;
    logic [1:0]                        r_full;
    logic                              r_wr_bank;
    logic                              r_rd_bank;
    logic [c_cnt_w-1:0]                r_wr_cnt;
    logic [7:0]                        r_fill_cnt;
    logic [7:0]                        r_sent_cnt;
    logic                              r_ovf;

    logic w_take_state;
    logic w_read_state;
    logic w_accept;
    logic w_drop;
    logic w_last;
    logic w_hs;

    // A full write bank blocks samples even if it is being drained this cycle.
    assign w_take_state = (r_state == c_st_idle) || (r_state == c_st_run);
    assign w_read_state = (r_state == c_st_run) || (r_state == c_st_drain);
    assign w_accept     = w_take_state && fir_valid && !r_full[r_wr_bank];
    assign w_drop       = w_take_state && fir_valid && r_full[r_wr_bank];
    assign w_last       = w_accept && (r_wr_cnt == c_last_word);
    assign w_hs         = frame_valid && frame_ready;

    assign frame_valid = w_read_state && r_full[r_rd_bank];
    assign frame_d     = r_bank[r_rd_bank];
    assign frame_idx   = r_sent_cnt;
    assign ovf         = r_ovf;
    assign done        = (r_state == c_st_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_bank     <= '0;
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_fill_cnt <= 8'd0;
            r_sent_cnt <= 8'd0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bank[r_wr_bank][r_wr_cnt] <= fir_d;
                if (w_last) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                    r_wr_cnt          <= '0;
                    r_fill_cnt        <= r_fill_cnt + 8'd1;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end

            // Fill and drain always target different banks, so both may update.
            if (w_hs) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
                r_sent_cnt        <= r_sent_cnt + 8'd1;
            end

            case (r_state)
                c_st_idle: begin
                    if (fir_valid) begin
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_last && ((r_fill_cnt + 8'd1) == c_total)) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (w_hs && ((r_sent_cnt + 8'd1) == c_total)) begin
                        r_state <= c_st_done;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_frame_ctrl                                                          |
// | Self-checking bench: vector table, directed corner cases, random vs model. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_fft_frame_ctrl;

    logic         clk;
    logic         rst;
    logic         fir_valid;
    logic [15:0]  fir_d;
    logic         frame_ready;

    logic         fv0, fv1;
    logic [255:0] fd0, fd1;
    logic [7:0]   idx0, idx1;
    logic         ovf0, ovf1;
    logic         done0, done1;

    int total = 0;
    int bad   = 0;

    fft_frame_ctrl #(.FRAME_LEN(16), .DW(16), .TOTAL_FRAMES(64)) dut0 (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .frame_valid(fv0), .frame_ready(frame_ready), .frame_d(fd0),
        .frame_idx(idx0), .ovf(ovf0), .done(done0)
    );

    fft_frame_ctrl #(.FRAME_LEN(16), .DW(16), .TOTAL_FRAMES(2)) dut1 (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .frame_valid(fv1), .frame_ready(frame_ready), .frame_d(fd1),
        .frame_idx(idx1), .ovf(ovf1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output view of whichever instance the random phase is checking.
    bit           sel;
    logic         cur_fv, cur_ovf, cur_done;
    logic [255:0] cur_fd;
    logic [7:0]   cur_idx;
    always_comb begin
        cur_fv   = sel ? fv1   : fv0;
        cur_fd   = sel ? fd1   : fd0;
        cur_idx  = sel ? idx1  : idx0;
        cur_ovf  = sel ? ovf1  : ovf0;
        cur_done = sel ? done1 : done0;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [255:0] ramp(input int base);
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) f[k*16 +: 16] = 16'(base + k);
        return f;
    endfunction

    task automatic do_reset(input bit check);
        rst         = 1'b1;
        fir_valid   = 1'($urandom_range(0, 1));
        fir_d       = 16'($urandom);
        frame_ready = 1'($urandom_range(0, 1));
        tick();
        if (check) begin
            chk("rst_valid", fv0, 0);
            chk("rst_data", fd0, 0);
            chk("rst_idx", idx0, 0);
            chk("rst_ovf", ovf0, 0);
            chk("rst_done", done0, 0);
            chk("rst_done1", done1, 0);
        end
        tick();
        rst         = 1'b0;
        fir_valid   = 1'b0;
        frame_ready = 1'b0;
        fir_d       = 16'd0;
    endtask

    // Behavioural model: a queue of completed frames (at most two buffered),
    // a partial frame, and counts of frames filled and handed over.
    int           m_total;
    int           m_phase;    // 0 idle, 1 run, 2 drain, 3 done
    logic [255:0] m_q[$];
    logic [255:0] m_part;
    int           m_pcnt, m_fill, m_sent;
    bit           m_ovf;

    task automatic model_reset(input int tot);
        m_total = tot; m_phase = 0; m_q.delete(); m_part = '0;
        m_pcnt = 0; m_fill = 0; m_sent = 0; m_ovf = 1'b0;
    endtask

    function automatic bit m_valid();
        return (m_phase == 1 || m_phase == 2) && (m_q.size() > 0);
    endfunction

    task automatic model_step(input bit v, input logic [15:0] d, input bit rdy);
        int           ph, qsz;
        bit           hs, take;
        logic [255:0] tmp;
        ph   = m_phase;
        qsz  = m_q.size();
        hs   = m_valid() && rdy;
        take = (ph == 0 || ph == 1) && v;
        if (hs) begin
            tmp = m_q.pop_front();
            m_sent++;
            if (ph == 2 && m_sent == m_total) m_phase = 3;
        end
        if (take) begin
            if (ph == 0) m_phase = 1;
            if (qsz == 2) begin
                m_ovf = 1'b1;
            end else begin
                m_part[m_pcnt*16 +: 16] = d;
                m_pcnt++;
                if (m_pcnt == 16) begin
                    m_q.push_back(m_part);
                    m_pcnt = 0;
                    m_fill++;
                    if (m_fill == m_total) m_phase = 2;
                end
            end
        end
    endtask

    task automatic run_random(input bit which, input int tot, input int cycles);
        bit          v, r;
        logic [15:0] d;
        sel = which;
        do_reset(1'b0);
        model_reset(tot);
        for (int c = 0; c < cycles; c++) begin
            chk("rnd_valid", cur_fv, m_valid());
            if (m_valid()) chk("rnd_data", cur_fd, m_q[0]);
            chk("rnd_idx", cur_idx, m_sent[7:0]);
            chk("rnd_ovf", cur_ovf, m_ovf);
            chk("rnd_done", cur_done, m_phase == 3);
            v = ($urandom_range(0, 99) < 75);
            r = ($urandom_range(0, 99) < 40);
            d = 16'($urandom);
            fir_valid = v; fir_d = d; frame_ready = r;
            model_step(v, d, r);
            tick();
        end
        chk("rnd_reached_done", cur_done, 1);
    endtask

    typedef struct {
        int n;
        bit gap;
        bit rdy;
        int exp_hs;
        bit exp_ovf;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int s, hs, cyc, hs1;

        tbl[0] = '{16, 1'b0, 1'b1, 1, 1'b0};
        tbl[1] = '{16, 1'b1, 1'b1, 1, 1'b0};
        tbl[2] = '{33, 1'b0, 1'b0, 0, 1'b1};
        tbl[3] = '{15, 1'b0, 1'b1, 0, 1'b0};
        tbl[4] = '{48, 1'b0, 1'b1, 3, 1'b0};
        tbl[5] = '{32, 1'b0, 1'b0, 0, 1'b0};

        sel = 1'b0;
        rst = 1'b0; fir_valid = 1'b0; fir_d = 16'd0; frame_ready = 1'b0;

        // Reset with random inputs, then idle: no frame without samples
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            frame_ready = 1'($urandom_range(0, 1));
            tick();
            chk("idle_no_valid", fv0, 0);
        end

        // Vector table
        for (int i = 0; i < 6; i++) begin
            do_reset(1'b0);
            frame_ready = tbl[i].rdy;
            s = 0; hs = 0; cyc = 0;
            while (s < tbl[i].n && cyc < 200) begin
                fir_valid = tbl[i].gap ? ((cyc % 2) == 0) : 1'b1;
                fir_d     = 16'(s);
                if (fv0 && frame_ready) begin
                    chk("vec_data", fd0, ramp(16 * hs));
                    chk("vec_idx", idx0, hs);
                    hs++;
                end
                if (fir_valid) s++;
                cyc++;
                tick();
            end
            fir_valid = 1'b0;
            for (int t = 0; t < 4; t++) begin
                if (fv0 && frame_ready) begin
                    chk("vec_data", fd0, ramp(16 * hs));
                    chk("vec_idx", idx0, hs);
                    hs++;
                end
                tick();
            end
            chk("vec_handshakes", hs, tbl[i].exp_hs);
            chk("vec_ovf", ovf0, tbl[i].exp_ovf);
        end

        // Single frame latency: valid exactly one cycle after the 16th edge
        do_reset(1'b0);
        frame_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            fir_valid = 1'b1; fir_d = 16'(k);
            chk("lat_not_yet", fv0, 0);
            tick();
        end
        fir_valid = 1'b0;
        chk("lat_valid", fv0, 1);
        chk("lat_data", fd0, ramp(0));
        chk("lat_idx", idx0, 0);
        tick();
        chk("lat_one_cycle", fv0, 0);
        chk("lat_idx_after", idx0, 1);

        // Backpressure: two banks fill, 33rd sample dropped, then back-to-back drain
        do_reset(1'b0);
        frame_ready = 1'b0;
        for (int k = 0; k < 33; k++) begin
            fir_valid = 1'b1; fir_d = 16'(k);
            if (k == 32) chk("bp_no_ovf_yet", ovf0, 0);
            tick();
        end
        fir_valid = 1'b0;
        chk("bp_ovf", ovf0, 1);
        chk("bp_valid", fv0, 1);
        chk("bp_data0", fd0, ramp(0));
        tick();
        chk("bp_hold_valid", fv0, 1);
        chk("bp_hold_data", fd0, ramp(0));
        chk("bp_hold_idx", idx0, 0);
        frame_ready = 1'b1;
        tick();
        chk("bp_b2b_valid", fv0, 1);
        chk("bp_data1", fd0, ramp(16));
        chk("bp_idx1", idx0, 1);
        tick();
        chk("bp_drained", fv0, 0);
        chk("bp_idx2", idx0, 2);
        chk("bp_ovf_sticky", ovf0, 1);
        frame_ready = 1'b0;

        // Completion with two frames on the small instance
        do_reset(1'b0);
        frame_ready = 1'b1;
        hs1 = 0;
        for (int k = 0; k < 52; k++) begin
            fir_valid = (k < 48); fir_d = 16'(k);
            chk("cmp_done", done1, hs1 == 2);
            if (fv1) begin
                chk("cmp_data", fd1, ramp(16 * hs1));
                chk("cmp_idx", idx1, hs1);
                hs1++;
            end
            tick();
        end
        chk("cmp_handshakes", hs1, 2);
        chk("cmp_done_final", done1, 1);
        chk("cmp_ovf", ovf1, 0);
        chk("cmp_valid_low", fv1, 0);
        fir_valid = 1'b0;

        // Asynchronous reset mid-frame, then a fresh frame
        do_reset(1'b0);
        frame_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            fir_valid = 1'b1; fir_d = 16'(16'h55 + k);
            tick();
        end
        fir_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_data", fd0, 0);
        chk("arst_idx", idx0, 0);
        chk("arst_valid", fv0, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            fir_valid = 1'b1; fir_d = 16'(100 + k);
            tick();
        end
        fir_valid = 1'b0;
        chk("arst_new_valid", fv0, 1);
        chk("arst_new_data", fd0, ramp(100));
        chk("arst_new_idx", idx0, 0);
        chk("arst_new_ovf", ovf0, 0);

        // Random traffic against the model on both instances
        run_random(1'b0, 64, 4000);
        run_random(1'b1, 2, 600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
